poly_voice_engine: RTL and testbench
====================================

Name: poly_voice_engine

Overview:
- Parametrised successor to the single-voice oscillator/waveshaper chain: NUM_VOICES phase-accumulator voices, time-multiplexed through one shared wave shaper and mixed into one SAMPLE_W-bit sample per sample tick.
- Sits between the keypad/mode logic, which writes voice configuration, and the pwm block, which consumes sample_o.
- Adds four selectable waveshapes and per-voice enable.

Parameters:
NUM_VOICES, 4, number of voices (power of two, >=2)
PHASE_W, 16, phase accumulator and increment width (>=9)
SAMPLE_W, 8, output sample width (must be 8; shaper uses phase[PHASE_W-1 -: 9])
SAMPLE_DIV, 256, clk cycles per output sample (must be >= NUM_VOICES+2)

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
cfg_we_i  input  1  config write strobe, one cycle
cfg_idx_i  input  $clog2(NUM_VOICES)+1  target voice; values >= NUM_VOICES ignored
cfg_inc_i  input  PHASE_W  phase increment per sample tick
cfg_en_i  input  1  voice enable
mode_i  input  2  waveshape: 00 square, 01 saw, 10 triangle, 11 pulse25
sample_o  output  SAMPLE_W  mixed sample
sample_valid_o  output  1  one-cycle strobe when sample_o updates
busy_o  output  1  high while the FSM is not IDLE

Behaviour:
- Reset (async, nrst=0): all phase, inc, en regs = 0; prescaler = 0; FSM = IDLE; accumulator = 0; sample_o = 0; sample_valid_o = 0; busy_o = 0. Reset mid-scan aborts the scan and produces no valid pulse.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick=1 when count==SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, go to ACCUM, set idx=0 and acc=0, and latch mode_i into mode_q.
  - ACCUM: one voice per cycle, idx = 0..NUM_VOICES-1. If en[idx]=1, acc += shape(phase[idx], mode_q) and phase[idx] += inc[idx] (mod 2^PHASE_W). If en[idx]=0, add 0 and hold phase at 0. After idx==NUM_VOICES-1, go to OUTPUT.
  - OUTPUT: sample_o <= acc >> $clog2(NUM_VOICES); sample_valid_o=1 for this single cycle; go to IDLE.
- Latency: a tick at cycle T gives ACCUM at cycles T+1..T+NUM_VOICES and OUTPUT at T+NUM_VOICES+1. sample_o and sample_valid_o are registered and visible at T+NUM_VOICES+2.
- A voice contributes the shape of its pre-advance phase. The sample for scan k therefore uses phase = k*inc.
- Accumulator width is SAMPLE_W+$clog2(NUM_VOICES). The mix never saturates; the shift averages.
- shape(p), with h = p[PHASE_W-1] and m = p[PHASE_W-2 -: 8]:
  - square: h ? 8'hFF : 8'h00
  - saw: p[PHASE_W-1 -: 8]
  - triangle: h ? ~m : m
  - pulse25: (p[PHASE_W-1 -: 2]==0) ? 8'hFF : 8'h00
- Config writes:
  - A write registers at the next clock edge and is accepted in any FSM state.
  - Writing cfg_en_i=0 forces that voice's phase to 0.
  - If the write hits the voice being processed in ACCUM that cycle: the contribution and phase advance use the old en/inc, then the write takes priority for the inc and en registers. A disable also forces phase to 0.
- mode_i changes mid-scan have no effect until the next tick.
- busy_o = (state != IDLE).

Decomposition:
- synth_pkg holds wave_mode_t (2-bit enum: SQUARE, SAW, TRI, PULSE25), eng_state_t (IDLE, ACCUM, OUTPUT), and constant SAMPLE_MAX=8'hFF.
- One combinational sub-module, phase_shaper: inputs phase[PHASE_W] and mode; output 8-bit shaped value.
- Prescaler, FSM, voice register file and accumulator all stay in poly_voice_engine.

Test Plan:
All scenarios use NUM_VOICES=4, PHASE_W=16, SAMPLE_DIV=16.
1. Reset, no writes -> sample_valid_o pulses once every 16 cycles, with the first pulse at cycle 21 after nrst deassert (tick at 15, ACCUM 16..19, OUTPUT 20, visible 21); sample_o=0 throughout; busy_o high 5 cycles per period.
2. Voice0 en, inc=16'h1000, mode=SAW -> successive samples 0,4,8,...,60, then wrap to 0 on the 17th sample.
3. All four voices en, inc=16'h8000, mode=SQUARE -> samples alternate 8'h00, 8'hFF.
4. Voice0 en, inc=16'h4000, mode=TRI -> samples repeat 8'h00, 8'h20, 8'h3F, 8'h1F; same run with mode=PULSE25 -> 8'h3F, 8'h00, 8'h00, 8'h00.
5. During the SAW run of test 2: write cfg_idx=5 -> no change to any voice. Write voice0 en=0 on the cycle idx==0 in ACCUM -> that scan's sample is still the old value; the next sample is 0; re-enabling restarts the sequence from phase 0.
6. Assert nrst for one cycle during ACCUM -> all outputs 0 immediately; no valid pulse for the aborted scan; voice config cleared, so the next sample is 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice engine.
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE  = 2'b00,
    SAW     = 2'b01,
    TRI     = 2'b10,
    PULSE25 = 2'b11
  } wave_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCUM  = 2'b01,
    OUTPUT = 2'b10
  } eng_state_t;

  localparam logic [7:0] SAMPLE_MAX = 8'hFF;

endpackage

// File: rtl/phase_shaper.sv
// Combinational wave shaper: maps the top 9 phase bits to an 8-bit level.
module phase_shaper
  import synth_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  wave_mode_t         mode_i,
  output logic [7:0]         shape_o
);

  logic       half;
  logic [7:0] mid;

  assign half = phase_i[PHASE_W-1];
  assign mid  = phase_i[PHASE_W-2 -: 8];

  always_comb begin
    shape_o = '0;
    case (mode_i)
      SQUARE:  shape_o = half ? SAMPLE_MAX : 8'h00;
      SAW:     shape_o = phase_i[PHASE_W-1 -: 8];
      TRI:     shape_o = half ? ~mid : mid;
      PULSE25: shape_o = (phase_i[PHASE_W-1 -: 2] == 2'b00) ? SAMPLE_MAX : 8'h00;
      default: shape_o = '0;
    endcase
  end

endmodule

// File: rtl/poly_voice_engine.sv
// NUM_VOICES phase-accumulator voices scanned one per cycle through a shared
// shaper and averaged into one sample per prescaler tick.
module poly_voice_engine
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_W   = 8,
  parameter int SAMPLE_DIV = 256
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NUM_VOICES):0]   cfg_idx_i,
  input  logic [PHASE_W-1:0]            cfg_inc_i,
  input  logic                          cfg_en_i,
  input  logic [1:0]                    mode_i,
  output logic [SAMPLE_W-1:0]           sample_o,
  output logic                          sample_valid_o,
  output logic                          busy_o,
  output eng_state_t                    dbg_state_o
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  eng_state_t          state_q, state_d;
  logic [VIDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  wave_mode_t          mode_q, mode_d;
  logic [PHASE_W-1:0]  phase_q [NUM_VOICES];
  logic [PHASE_W-1:0]  phase_d [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0]  inc_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;

  logic                tick;
  logic                cfg_hit;
  logic [VIDX_W-1:0]   cfg_v;
  logic [7:0]          shape;

  assign tick    = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign cfg_hit = cfg_we_i && (cfg_idx_i < (VIDX_W + 1)'(NUM_VOICES));
  assign cfg_v   = cfg_idx_i[VIDX_W-1:0];

  phase_shaper #(.PHASE_W(PHASE_W)) u_shaper (
    .phase_i (phase_q[idx_q]),
    .mode_i  (mode_q),
    .shape_o (shape)
  );

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    phase_d  = phase_q;
    inc_d    = inc_q;
    en_d     = en_q;
    sample_d = sample_q;
    valid_d  = (state_q == OUTPUT);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
          mode_d  = wave_mode_t'(mode_i);
        end
      end
      ACCUM: begin
        // The voice contributes its pre-advance phase; disabled voices park at 0.
        if (en_q[idx_q]) begin
          acc_d          = acc_q + ACC_W'(shape);
          phase_d[idx_q] = phase_q[idx_q] + inc_q[idx_q];
        end else begin
          phase_d[idx_q] = '0;
        end
        if (idx_q == VIDX_W'(NUM_VOICES - 1)) begin
          state_d = OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUTPUT: begin
        sample_d = SAMPLE_W'(acc_q >> VIDX_W);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Config strobe overrides the scan's register update for the same voice.
    if (cfg_hit) begin
      inc_d[cfg_v] = cfg_inc_i;
      en_d[cfg_v]  = cfg_en_i;
      if (!cfg_en_i) begin
        phase_d[cfg_v] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      mode_q   <= SQUARE;
      phase_q  <= '{default: '0};
      inc_q    <= '{default: '0};
      en_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      inc_q    <= inc_d;
      en_q     <= en_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_poly_voice_engine.sv
// Randomized and directed bench for poly_voice_engine against a per-scan voice model.
module tb_poly_voice_engine;
  import synth_pkg::*;

  localparam int NV = 4;
  localparam int PW = 16;
  localparam int SW = 8;
  localparam int SD = 16;

  localparam logic [7:0] TRI_EXP [4] = '{8'h00, 8'h20, 8'h3F, 8'h1F};
  localparam logic [7:0] PUL_EXP [4] = '{8'h3F, 8'h00, 8'h00, 8'h00};

  // clock / reset
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [15:0] cfg_inc = '0;
  logic        cfg_en = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  sample;
  logic        valid;
  logic        busy;
  eng_state_t  dbg_state;

  poly_voice_engine #(
    .NUM_VOICES (NV),
    .PHASE_W    (PW),
    .SAMPLE_W   (SW),
    .SAMPLE_DIV (SD)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_inc_i      (cfg_inc),
    .cfg_en_i       (cfg_en),
    .mode_i         (mode),
    .sample_o       (sample),
    .sample_valid_o (valid),
    .busy_o         (busy),
    .dbg_state_o    (dbg_state)
  );

  // scoreboard and reference model state
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  hist_q [$];
  logic [7:0]  exp_sample;
  logic [1:0]  drv_mode = '0;
  logic [15:0] m_phase [NV];
  logic [15:0] m_inc [NV];
  logic        m_en [NV];
  int          m_sum;
  logic [1:0]  m_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_shape(input logic [15:0] p, input logic [1:0] md);
    logic       h;
    logic [7:0] m;
    h = p[15];
    m = p[14:7];
    case (md)
      2'd0:    return h ? 8'hFF : 8'h00;
      2'd1:    return p[15:8];
      2'd2:    return h ? ~m : m;
      default: return (p[15:14] == 2'b00) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = '0;
      m_inc[i]   = '0;
      m_en[i]    = 1'b0;
    end
    exp_q.delete();
    m_sum      = 0;
    m_mode     = '0;
    exp_sample = '0;
    cyc        = 0;
  endtask

  // Called at the negedge in the middle of cycle cyc: check, drive, model, advance.
  task automatic step(input logic we, input logic [2:0] idx, input logic [15:0] inc, input logic en);
    int   pos;
    logic exp_valid;
    logic exp_busy;
    pos       = cyc % SD;
    exp_valid = (cyc >= SD + NV + 1) && (pos == NV + 1);
    exp_busy  = (cyc >= SD) && (pos <= NV);
    if (exp_valid && exp_q.size() > 0) exp_sample = exp_q.pop_front();
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("dbg_idle", 32'(dbg_state == IDLE), 32'(!exp_busy));
    chk("sample", 32'(sample), 32'(exp_sample));
    if (valid) hist_q.push_back(sample);

    cfg_we  = we;
    cfg_idx = idx;
    cfg_inc = inc;
    cfg_en  = en;
    mode    = drv_mode;

    if (pos == SD - 1) m_mode = drv_mode;
    if (cyc >= SD && pos < NV) begin
      if (pos == 0) m_sum = 0;
      if (m_en[pos]) begin
        m_sum        += int'(ref_shape(m_phase[pos], m_mode));
        m_phase[pos] += m_inc[pos];
      end else begin
        m_phase[pos] = '0;
      end
    end
    if (cyc >= SD && pos == NV) exp_q.push_back(8'(m_sum / NV));
    if (we && idx < NV) begin
      m_inc[idx] = inc;
      m_en[idx]  = en;
      if (!en) m_phase[idx] = '0;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Entered at a negedge; asserts reset immediately (may abort a scan).
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_sample", 32'(sample), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    cfg_we = 1'b0;
    model_clear();
    hist_q.delete();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic idle_steps(input int count);
    for (int i = 0; i < count; i++) step(1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic run_samples(input int count, input int budget);
    int b;
    b = 0;
    while (hist_q.size() < count && b < budget) begin
      step(1'b0, 3'd0, 16'h0, 1'b0);
      b++;
    end
    chk("sample_count", 32'(hist_q.size()), 32'(count));
  endtask

  task automatic wait_pos(input int p);
    int b;
    b = 0;
    while (!(cyc >= SD && cyc % SD == p) && b < 4 * SD) begin
      step(1'b0, 3'd0, 16'h0, 1'b0);
      b++;
    end
    chk("wait_pos", 32'(cyc % SD), 32'(p));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // idle engine: periodic zero samples
    drv_mode = 2'(($urandom_range(0, 3)));
    run_samples(3, 4 * SD + 8);
    for (int k = 0; k < 3; k++) chk("idle_zero", 32'(hist_q[k]), 32'h0);

    // saw on voice 0
    do_reset();
    drv_mode = 2'd1;
    step(1'b1, 3'd0, 16'h1000, 1'b1);
    run_samples(17, 18 * SD);
    for (int k = 0; k < 17; k++) chk("saw_seq", 32'(hist_q[k]), 32'(4 * (k % 16)));

    // out-of-range index, then disable exactly on voice 0's ACCUM cycle
    step(1'b1, 3'd5, 16'hFFFF, 1'b1);
    wait_pos(0);
    hist_q.delete();
    step(1'b1, 3'd0, 16'h1000, 1'b0);
    run_samples(2, 3 * SD);
    chk("dis_old", 32'(hist_q[0]), 32'h04);
    chk("dis_zero", 32'(hist_q[1]), 32'h00);
    hist_q.delete();
    step(1'b1, 3'd0, 16'h1000, 1'b1);
    run_samples(3, 4 * SD);
    for (int k = 0; k < 3; k++) chk("reen_seq", 32'(hist_q[k]), 32'(4 * k));

    // all voices square at half rate
    do_reset();
    drv_mode = 2'd0;
    for (int v = 0; v < NV; v++) step(1'b1, 3'(v), 16'h8000, 1'b1);
    run_samples(4, 5 * SD);
    for (int k = 0; k < 4; k++) chk("square_seq", 32'(hist_q[k]), (k % 2) ? 32'hFF : 32'h00);

    // triangle and pulse25 on voice 0
    do_reset();
    drv_mode = 2'd2;
    step(1'b1, 3'd0, 16'h4000, 1'b1);
    run_samples(4, 5 * SD);
    for (int k = 0; k < 4; k++) chk("tri_seq", 32'(hist_q[k]), 32'(TRI_EXP[k]));
    do_reset();
    drv_mode = 2'd3;
    step(1'b1, 3'd0, 16'h4000, 1'b1);
    run_samples(4, 5 * SD);
    for (int k = 0; k < 4; k++) chk("pulse_seq", 32'(hist_q[k]), 32'(PUL_EXP[k]));

    // reset in the middle of a scan with a non-zero sample on the output
    do_reset();
    drv_mode = 2'd1;
    step(1'b1, 3'd0, 16'h4000, 1'b1);
    step(1'b1, 3'd1, 16'h2000, 1'b1);
    run_samples(2, 3 * SD);
    wait_pos(1);
    do_reset();
    run_samples(2, 3 * SD);
    chk("post_rst", 32'(hist_q[0]), 32'h0);

    // random config writes and mode changes, including hits on the active voice
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drv_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0)
        step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 3) != 0);
      else
        step(1'b0, 3'd0, 16'h0, 1'b0);
    end
    idle_steps(2 * SD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
